// File: rtl/x_in_conditioner_if.sv
// Signal bundle between the raw-input conditioner and its environment:
// raw level and clear in, conditioned level, edge pulses and debug out.
interface x_in_conditioner_if #(
  parameter int GLITCH_W = 8
);
  logic                raw_in;
  logic                glitch_clr;
  logic                x_clean;
  logic                x_rise;
  logic                x_fall;
  logic [GLITCH_W-1:0] glitch_cnt;
  logic [1:0]          state_dbg;

  modport master (
    output raw_in, glitch_clr,
    input  x_clean, x_rise, x_fall, glitch_cnt, state_dbg
  );

  modport slave (
    input  raw_in, glitch_clr,
    output x_clean, x_rise, x_fall, glitch_cnt, state_dbg
  );
endinterface

// File: rtl/x_in_conditioner.sv
// Debounces an asynchronous raw level into x_clean for the downstream T-FF
// state machine, with registered edge pulses and a saturating glitch counter.
module x_in_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int GLITCH_W = 8
) (
  input logic          clock,
  input logic          reset,
  x_in_conditioner_if.slave bus
);
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    PEND_LO   = 2'b10,
    STABLE_HI = 2'b11
  } state_t;

  localparam logic [7:0]          CNT_LAST = 8'(DEBOUNCE - 1);
  localparam logic [GLITCH_W-1:0] GMAX     = '1;
  localparam logic [GLITCH_W-1:0] GONE     = {{(GLITCH_W-1){1'b0}}, 1'b1};

  logic                s1, s2;
  state_t              state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic                clean, clean_n;
  logic                rise, rise_n;
  logic                fall, fall_n;
  logic                glitch_inc;
  logic [GLITCH_W-1:0] gcnt, gcnt_n;

  // two-flop synchronizer; only s2 is seen by the FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.raw_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= STABLE_LO;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      clean <= clean_n;
      rise  <= rise_n;
      fall  <= fall_n;
      gcnt  <= gcnt_n;
    end
  end

  // cnt holds how many consecutive samples of the new level have been seen
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    clean_n    = clean;
    rise_n     = 1'b0;
    fall_n     = 1'b0;
    glitch_inc = 1'b0;
    case (state)
      STABLE_LO: if (s2) begin
        state_n = PEND_HI;
        cnt_n   = 8'd1;
      end
      PEND_HI: begin
        if (!s2) begin
          state_n    = STABLE_LO;
          cnt_n      = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
          clean_n = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      STABLE_HI: if (!s2) begin
        state_n = PEND_LO;
        cnt_n   = 8'd1;
      end
      PEND_LO: begin
        if (s2) begin
          state_n    = STABLE_HI;
          cnt_n      = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
          clean_n = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = STABLE_LO;
        cnt_n   = '0;
        clean_n = 1'b0;
      end
    endcase
  end

  // clear has priority over a same-cycle abort
  always_comb begin
    gcnt_n = gcnt;
    if (bus.glitch_clr)
      gcnt_n = '0;
    else if (glitch_inc && gcnt != GMAX)
      gcnt_n = gcnt + GONE;
  end

  assign bus.x_clean    = clean;
  assign bus.x_rise     = rise;
  assign bus.x_fall     = fall;
  assign bus.glitch_cnt = gcnt;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_x_in_conditioner.sv
// Self-checking bench for x_in_conditioner: per-cycle vector table through a
// scoreboard queue, plus directed saturation, clear and async-reset sequences.
module tb_x_in_conditioner;
  logic clock = 1'b0;
  logic reset;

  x_in_conditioner_if #(.GLITCH_W(8)) bus ();

  x_in_conditioner #(.DEBOUNCE(4), .GLITCH_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       raw;
    logic       clr;
    logic       c;
    logic       r;
    logic       f;
    logic [7:0] g;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic seen_rise;

  function automatic void add(input logic raw, clr, c, r, f,
                              input logic [7:0] g, input logic [1:0] st,
                              input int n);
    vec_t v;
    v.raw = raw; v.clr = clr; v.c = c; v.r = r; v.f = f; v.g = g; v.st = st;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c);
    @(negedge clock);
    bus.raw_in     = r;
    bus.glitch_clr = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t e;
    logic [12:0] act, want;

    // rows: raw clr | clean rise fall glitch state | repeat
    add(0,0, 0,0,0, 0, 2'b00, 10);  // idle after reset
    add(1,0, 0,0,0, 0, 2'b00, 2);   // rise: sync latency
    add(1,0, 0,0,0, 0, 2'b01, 3);
    add(1,0, 1,1,0, 0, 2'b11, 1);
    add(1,0, 1,0,0, 0, 2'b11, 2);
    add(0,0, 1,0,0, 0, 2'b11, 2);   // fall
    add(0,0, 1,0,0, 0, 2'b10, 3);
    add(0,0, 0,0,1, 0, 2'b00, 1);
    add(0,0, 0,0,0, 0, 2'b00, 2);
    add(1,0, 0,0,0, 0, 2'b00, 2);   // 3-sample pulse aborts
    add(1,0, 0,0,0, 0, 2'b01, 1);
    add(0,0, 0,0,0, 0, 2'b01, 2);
    add(0,0, 0,0,0, 1, 2'b00, 4);
    add(1,0, 0,0,0, 1, 2'b00, 2);   // rise again
    add(1,0, 0,0,0, 1, 2'b01, 3);
    add(1,0, 1,1,0, 1, 2'b11, 1);
    add(1,0, 1,0,0, 1, 2'b11, 2);
    add(0,0, 1,0,0, 1, 2'b11, 2);   // short low dip aborts PEND_LO
    add(1,0, 1,0,0, 1, 2'b10, 2);
    add(1,0, 1,0,0, 2, 2'b11, 4);
    add(0,0, 1,0,0, 2, 2'b11, 2);   // back low
    add(0,0, 1,0,0, 2, 2'b10, 3);
    add(0,0, 0,0,1, 2, 2'b00, 1);
    add(0,0, 0,0,0, 2, 2'b00, 2);
    add(0,1, 0,0,0, 0, 2'b00, 1);   // plain clear
    add(0,0, 0,0,0, 0, 2'b00, 2);

    reset          = 1'b0;
    bus.raw_in     = 1'b0;
    bus.glitch_clr = 1'b0;
    #1;
    chk("reset_outputs", {19'd0, bus.x_clean, bus.x_rise, bus.x_fall, bus.glitch_cnt, bus.state_dbg}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      bus.raw_in     = vecs[i].raw;
      bus.glitch_clr = vecs[i].clr;
      exp_q.push_back(vecs[i]);
      @(posedge clock);
      #1;
      e    = exp_q.pop_front();
      act  = {bus.x_clean, bus.x_rise, bus.x_fall, bus.glitch_cnt, bus.state_dbg};
      want = {e.c, e.r, e.f, e.g, e.st};
      if (act !== want) begin
        n_err++;
        $display("FAIL vec%0d: got clean/rise/fall/glitch/state=%b/%b/%b/%0d/%b, want %b/%b/%b/%0d/%b",
                 i, act[12], act[11], act[10], act[9:2], act[1:0],
                 want[12], want[11], want[10], want[9:2], want[1:0]);
      end
      n_vec++;
    end

    // single-cycle pulses: every one aborts, count saturates at 255
    seen_rise = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1, 0); seen_rise |= bus.x_rise;
      step(0, 0); seen_rise |= bus.x_rise;
    end
    repeat (4) step(0, 0);
    chk("glitch_100", {24'd0, bus.glitch_cnt}, 32'd100);
    for (int i = 0; i < 200; i++) begin
      step(1, 0); seen_rise |= bus.x_rise;
      step(0, 0); seen_rise |= bus.x_rise;
    end
    repeat (4) step(0, 0);
    chk("glitch_sat", {24'd0, bus.glitch_cnt}, 32'd255);
    chk("pulses_no_rise", {31'd0, seen_rise}, 32'd0);
    chk("pulses_clean_lo", {31'd0, bus.x_clean}, 32'd0);

    // clear coincident with an abort
    step(1, 0);
    step(0, 0);
    step(0, 0);
    chk("pend_before_clr", {30'd0, bus.state_dbg}, 32'd1);
    step(0, 1);
    chk("clr_beats_inc", {24'd0, bus.glitch_cnt}, 32'd0);
    chk("clr_abort_state", {30'd0, bus.state_dbg}, 32'd0);

    // one more glitch so reset has something to discard
    step(1, 0);
    repeat (4) step(0, 0);
    chk("glitch_one", {24'd0, bus.glitch_cnt}, 32'd1);

    // reset mid-PEND_HI with cnt == 2
    repeat (4) step(1, 0);
    chk("pend_cnt2_state", {30'd0, bus.state_dbg}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_state", {30'd0, bus.state_dbg}, 32'd0);
    chk("async_rst_glitch", {24'd0, bus.glitch_cnt}, 32'd0);
    chk("async_rst_clean", {31'd0, bus.x_clean}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock);
      #1;
      if (i == 5) chk("post_rst_edge5", {31'd0, bus.x_clean}, 32'd0);
      if (i == 6) chk("post_rst_edge6", {30'd0, bus.x_clean, bus.x_rise}, 32'd3);
    end

    // async reset from stable high clears x_clean without an edge
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_hi", {29'd0, bus.x_clean, bus.state_dbg}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
